// File: rtl/tlul_xbar_nxm_pkg.sv
// Shared TL-UL types, crossbar width helpers and the address window match.
package tlul_xbar_nxm_pkg;

    typedef enum logic [2:0] {PutFullData = 3'd0, PutPartialData = 3'd1, Get = 3'd4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'd0, AccessAckData = 3'd1} tl_d_op_e;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int host_id_w(input int n_hosts);
        return clog2_min1(n_hosts);
    endfunction

    // The error responder takes the index just past the last device.
    function automatic int dev_idx_w(input int n_devs);
        return clog2_min1(n_devs + 1);
    endfunction

    function automatic logic dev_decode(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Small synchronous FIFO with a combinational head, used to hold return host IDs.
module prim_fifo_sync #(
    parameter int Width = 1,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             rvalid,
    input  logic             rready,
    output logic [Width-1:0] rdata
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr_reg, rptr_reg;
    logic [CntW-1:0]  cnt_reg;
    logic             push, pop;

    assign full   = (cnt_reg == CntW'(Depth));
    assign rvalid = (cnt_reg != '0);
    assign rdata  = mem[rptr_reg];
    assign push   = wvalid && !full;
    assign pop    = rready && rvalid;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (push) wptr_reg <= ptr_inc(wptr_reg);
            if (pop)  rptr_reg <= ptr_inc(rptr_reg);
            if (push && !pop)      cnt_reg <= cnt_reg + CntW'(1);
            else if (!push && pop) cnt_reg <= cnt_reg - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_reg] <= wdata;
    end

endmodule

// File: rtl/tlul_xbar_err_resp.sv
// Single-entry responder that answers every unmapped access with d_error set.
module tlul_xbar_err_resp
    import tlul_xbar_nxm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       a_valid,
    input  tl_a_op_e   a_opcode,
    input  logic [7:0] a_source,
    input  logic [1:0] a_size,
    input  logic       d_ready,
    output tl_d2h_t    rsp
);
    logic       full_reg;
    tl_a_op_e   op_reg;
    logic [7:0] source_reg;
    logic [1:0] size_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_reg   <= 1'b0;
            op_reg     <= Get;
            source_reg <= '0;
            size_reg   <= '0;
        end else if (!full_reg && a_valid) begin
            full_reg   <= 1'b1;
            op_reg     <= a_opcode;
            source_reg <= a_source;
            size_reg   <= a_size;
        end else if (full_reg && d_ready) begin
            full_reg <= 1'b0;
        end
    end

    always_comb begin
        rsp          = '0;
        rsp.a_ready  = !full_reg;
        rsp.d_valid  = full_reg;
        rsp.d_error  = 1'b1;
        rsp.d_source = source_reg;
        rsp.d_size   = size_reg;
        rsp.d_opcode = (op_reg == Get) ? AccessAckData : AccessAck;
        rsp.d_data   = (op_reg == Get) ? ERR_DATA : 32'h0;
    end

endmodule

// File: rtl/tlul_xbar_nxm.sv
// N-host to M-device TL-UL crossbar with per-device round-robin arbitration
// and FIFO-tracked response routing; unmapped accesses go to an error responder.
module tlul_xbar_nxm
    import tlul_xbar_nxm_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int NumDevs        = 4,
    parameter int MaxOutstanding = 4,
    parameter int DevFifoDepth   = 4,
    parameter logic [NumDevs-1:0][31:0] DevBase = {32'h0003_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_0000},
    parameter logic [NumDevs-1:0][31:0] DevMask = {NumDevs{32'h0000_FFFF}}
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o [NumDevs],
    input  tl_d2h_t tl_d_i [NumDevs]
);
    localparam int NumPorts = NumDevs + 1;
    localparam int HostW    = host_id_w(NumHosts);
    localparam int DevW     = dev_idx_w(NumDevs);
    localparam int CntW     = $clog2(MaxOutstanding + 1);

    logic [DevW-1:0]     target [NumHosts];
    logic [NumHosts-1:0] stall;
    logic [NumHosts-1:0] gnt [NumPorts];
    tl_d2h_t             port_rsp [NumPorts];
    logic [HostW-1:0]    head [NumPorts];
    logic [NumPorts-1:0] fifo_nempty;

    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host
        logic [CntW-1:0] cnt_reg;
        logic [DevW-1:0] cur_dev_reg;
        logic [DevW-1:0] tgt;
        logic            dsel, a_hs, d_hs;
        tl_d2h_t         rsp;

        // Descending scan so the lowest matching window wins.
        always_comb begin
            tgt = DevW'(NumDevs);
            for (int k = NumDevs - 1; k >= 0; k--) begin
                if (dev_decode(tl_h_i[gi].a_address, DevBase[k], DevMask[k])) tgt = DevW'(k);
            end
        end

        assign target[gi] = tgt;
        // Switching device only with nothing in flight keeps this host's responses ordered.
        assign stall[gi]  = (cnt_reg == CntW'(MaxOutstanding)) ||
                            ((cnt_reg != '0) && (tgt != cur_dev_reg));
        assign dsel       = (cnt_reg != '0) && fifo_nempty[cur_dev_reg] &&
                            (head[cur_dev_reg] == HostW'(gi));

        always_comb begin
            rsp         = port_rsp[cur_dev_reg];
            rsp.d_valid = dsel && port_rsp[cur_dev_reg].d_valid;
            rsp.a_ready = gnt[tgt][gi] && port_rsp[tgt].a_ready;
        end

        assign tl_h_o[gi] = rsp;
        assign a_hs       = tl_h_i[gi].a_valid && rsp.a_ready;
        assign d_hs       = rsp.d_valid && tl_h_i[gi].d_ready;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg     <= '0;
                cur_dev_reg <= '0;
            end else begin
                if (a_hs && !d_hs)      cnt_reg <= cnt_reg + CntW'(1);
                else if (!a_hs && d_hs) cnt_reg <= cnt_reg - CntW'(1);
                if (a_hs) cur_dev_reg <= tgt;
            end
        end
    end

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        logic [HostW-1:0]    ptr_reg, win, head_id;
        logic [NumHosts-1:0] elig;
        logic                any, full, nempty, a_hs_p, d_hs_p;
        int                  idx;
        tl_h2d_t             req;
        tl_d2h_t             rsp;

        always_comb begin
            elig = '0;
            win  = ptr_reg;
            any  = 1'b0;
            idx  = 0;
            for (int h = 0; h < NumHosts; h++) begin
                elig[h] = tl_h_i[h].a_valid && !stall[h] && (target[h] == DevW'(gi));
            end
            for (int i = 0; i < NumHosts; i++) begin
                idx = (int'(ptr_reg) + i) % NumHosts;
                if (!any && elig[idx]) begin
                    any = 1'b1;
                    win = HostW'(idx);
                end
            end
        end

        always_comb begin
            req         = tl_h_i[win];
            req.a_valid = any && !full;
            req.d_ready = nempty && tl_h_i[head_id].d_ready;
        end

        assign a_hs_p          = req.a_valid && rsp.a_ready;
        assign d_hs_p          = rsp.d_valid && req.d_ready;
        assign gnt[gi]         = (any && !full) ? (NumHosts'(1) << win) : '0;
        assign port_rsp[gi]    = rsp;
        assign head[gi]        = head_id;
        assign fifo_nempty[gi] = nempty;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) ptr_reg <= '0;
            else if (a_hs_p) ptr_reg <= (int'(win) == NumHosts - 1) ? '0 : win + HostW'(1);
        end

        prim_fifo_sync #(.Width(HostW), .Depth(DevFifoDepth)) u_ret_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .wvalid (a_hs_p),
            .wdata  (win),
            .full   (full),
            .rvalid (nempty),
            .rready (d_hs_p),
            .rdata  (head_id)
        );

        if (gi < NumDevs) begin : g_dev
            assign tl_d_o[gi] = req;
            assign rsp        = tl_d_i[gi];
        end else begin : g_err
            logic unused_req;
            assign unused_req = ^{req.a_param, req.a_address, req.a_mask, req.a_data};
            tlul_xbar_err_resp u_err (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .a_valid  (req.a_valid),
                .a_opcode (req.a_opcode),
                .a_source (req.a_source),
                .a_size   (req.a_size),
                .d_ready  (req.d_ready),
                .rsp      (rsp)
            );
        end
    end

endmodule

// File: tb/tb_tlul_xbar_nxm.sv
// Directed bench for the 2x4 crossbar: decode, arbitration, routing, limits, reset.
module tb_tlul_xbar_nxm;
    import tlul_xbar_nxm_pkg::*;

    logic    clk;
    logic    rst_ni;
    tl_h2d_t h_req [2];
    tl_d2h_t h_rsp [2];
    tl_h2d_t d_req [4];
    tl_d2h_t d_rsp [4];
    int      vectors;
    int      miscompares;

    tlul_xbar_nxm dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .tl_h_i (h_req),
        .tl_h_o (h_rsp),
        .tl_d_o (d_req),
        .tl_d_i (d_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] dev_valids();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = d_req[k].a_valid;
        return v;
    endfunction

    task automatic host_req(input int h, input tl_a_op_e op, input logic [31:0] addr,
                            input logic [7:0] src);
        h_req[h].a_valid   = 1'b1;
        h_req[h].a_opcode  = op;
        h_req[h].a_address = addr;
        h_req[h].a_source  = src;
        h_req[h].a_size    = 2'd2;
        h_req[h].a_mask    = 4'hF;
    endtask

    task automatic dev_resp(input int k, input logic v, input logic [7:0] src,
                            input logic [31:0] data);
        d_rsp[k].d_valid  = v;
        d_rsp[k].d_opcode = AccessAckData;
        d_rsp[k].d_source = src;
        d_rsp[k].d_data   = data;
        d_rsp[k].d_error  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int h = 0; h < 2; h++) begin
            h_req[h] = '0;
            h_req[h].d_ready = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            d_rsp[k] = '0;
            d_rsp[k].a_ready = 1'b1;
        end
        repeat (3) step();
        vectors++; if (dev_valids() !== 4'b0000) begin miscompares++;
            $display("FAIL rst_dev_avalid: got %b want 0000", dev_valids()); end
        for (int h = 0; h < 2; h++) begin
            vectors++; if (h_rsp[h].d_valid !== 1'b0) begin miscompares++;
                $display("FAIL rst_host%0d_dvalid: got %b want 0", h, h_rsp[h].d_valid); end
            vectors++; if (h_rsp[h].a_ready !== 1'b0) begin miscompares++;
                $display("FAIL rst_host%0d_aready: got %b want 0", h, h_rsp[h].a_ready); end
        end
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        host_req(0, Get, 32'h0002_0010, 8'h05);
        @(negedge clk);
        vectors++; if (dev_valids() !== 4'b0100) begin miscompares++;
            $display("FAIL rd_dev_avalid: got %b want 0100", dev_valids()); end
        vectors++; if (d_req[2].a_address !== 32'h0002_0010) begin miscompares++;
            $display("FAIL rd_addr: got %h want 00020010", d_req[2].a_address); end
        vectors++; if (h_rsp[0].a_ready !== 1'b1) begin miscompares++;
            $display("FAIL rd_aready: got %b want 1", h_rsp[0].a_ready); end
        step();
        h_req[0].a_valid = 1'b0;
        dev_resp(2, 1'b1, 8'h05, 32'h1234_5678);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[0].d_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rd_resp: got v=%b d=%h want v=1 d=12345678", h_rsp[0].d_valid, h_rsp[0].d_data); end
        vectors++; if (h_rsp[0].d_error !== 1'b0 || h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL rd_err_route: got err=%b h1v=%b want 0 0", h_rsp[0].d_error, h_rsp[1].d_valid); end
        step();
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b0 || d_req[2].d_ready !== 1'b0) begin miscompares++;
            $display("FAIL rd_spurious: got v=%b rdy=%b want 0 0", h_rsp[0].d_valid, d_req[2].d_ready); end
        step();
        dev_resp(2, 1'b0, 8'h00, 32'h0);
        $display("test_single_read done");
    endtask

    task automatic test_contention();
        host_req(0, Get, 32'h0000_0004, 8'h10);
        host_req(1, Get, 32'h0000_0004, 8'h11);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1 || h_rsp[1].a_ready !== 1'b0) begin miscompares++;
            $display("FAIL cont_c1: got r0=%b r1=%b want 1 0", h_rsp[0].a_ready, h_rsp[1].a_ready); end
        vectors++; if (d_req[0].a_source !== 8'h10) begin miscompares++;
            $display("FAIL cont_c1_src: got %h want 10", d_req[0].a_source); end
        step();
        host_req(0, Get, 32'h0000_0004, 8'h12);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b0 || h_rsp[1].a_ready !== 1'b1) begin miscompares++;
            $display("FAIL cont_c2: got r0=%b r1=%b want 0 1", h_rsp[0].a_ready, h_rsp[1].a_ready); end
        vectors++; if (d_req[0].a_source !== 8'h11) begin miscompares++;
            $display("FAIL cont_c2_src: got %h want 11", d_req[0].a_source); end
        step();
        h_req[1].a_valid = 1'b0;
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1 || d_req[0].a_source !== 8'h12) begin miscompares++;
            $display("FAIL cont_c3: got r0=%b src=%h want 1 12", h_rsp[0].a_ready, d_req[0].a_source); end
        step();
        h_req[0].a_valid = 1'b0;
        dev_resp(0, 1'b1, 8'h10, 32'hAAAA_0000);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[1].d_valid !== 1'b0 ||
                       h_rsp[0].d_data !== 32'hAAAA_0000) begin miscompares++;
            $display("FAIL cont_r1: got v0=%b v1=%b d=%h want 1 0 aaaa0000",
                     h_rsp[0].d_valid, h_rsp[1].d_valid, h_rsp[0].d_data); end
        step();
        dev_resp(0, 1'b1, 8'h11, 32'hBBBB_0001);
        @(negedge clk);
        vectors++; if (h_rsp[1].d_valid !== 1'b1 || h_rsp[0].d_valid !== 1'b0 ||
                       h_rsp[1].d_data !== 32'hBBBB_0001) begin miscompares++;
            $display("FAIL cont_r2: got v0=%b v1=%b d=%h want 0 1 bbbb0001",
                     h_rsp[0].d_valid, h_rsp[1].d_valid, h_rsp[1].d_data); end
        step();
        dev_resp(0, 1'b1, 8'h12, 32'hCCCC_0002);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL cont_r3: got v0=%b v1=%b want 1 0", h_rsp[0].d_valid, h_rsp[1].d_valid); end
        step();
        dev_resp(0, 1'b0, 8'h00, 32'h0);
        // Last grant went to host 0, so host 1 now has priority.
        host_req(0, Get, 32'h0000_0004, 8'h13);
        host_req(1, Get, 32'h0000_0004, 8'h14);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b0 || h_rsp[1].a_ready !== 1'b1) begin miscompares++;
            $display("FAIL cont_ptr: got r0=%b r1=%b want 0 1", h_rsp[0].a_ready, h_rsp[1].a_ready); end
        #1;
        h_req[0].a_valid = 1'b0;
        h_req[1].a_valid = 1'b0;
        step();
        $display("test_contention done");
    endtask

    task automatic test_unmapped();
        host_req(1, Get, 32'h0005_0000, 8'h21);
        @(negedge clk);
        vectors++; if (h_rsp[1].a_ready !== 1'b1 || dev_valids() !== 4'b0000) begin miscompares++;
            $display("FAIL err_get_accept: got r=%b dv=%b want 1 0000", h_rsp[1].a_ready, dev_valids()); end
        vectors++; if (h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL err_get_early: got %b want 0", h_rsp[1].d_valid); end
        step();
        h_req[1].a_valid = 1'b0;
        @(negedge clk);
        vectors++; if (h_rsp[1].d_valid !== 1'b1 || h_rsp[1].d_opcode !== AccessAckData ||
                       h_rsp[1].d_error !== 1'b1) begin miscompares++;
            $display("FAIL err_get_rsp: got v=%b op=%0d e=%b want 1 1 1",
                     h_rsp[1].d_valid, h_rsp[1].d_opcode, h_rsp[1].d_error); end
        vectors++; if (h_rsp[1].d_data !== 32'hFFFF_FFFF || h_rsp[1].d_source !== 8'h21) begin miscompares++;
            $display("FAIL err_get_data: got d=%h s=%h want ffffffff 21", h_rsp[1].d_data, h_rsp[1].d_source); end
        step();
        host_req(1, PutFullData, 32'h0005_0000, 8'h22);
        @(negedge clk);
        vectors++; if (h_rsp[1].a_ready !== 1'b1 || h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL err_put_accept: got r=%b v=%b want 1 0", h_rsp[1].a_ready, h_rsp[1].d_valid); end
        step();
        h_req[1].a_valid = 1'b0;
        @(negedge clk);
        vectors++; if (h_rsp[1].d_valid !== 1'b1 || h_rsp[1].d_opcode !== AccessAck ||
                       h_rsp[1].d_error !== 1'b1 || h_rsp[1].d_data !== 32'h0) begin miscompares++;
            $display("FAIL err_put_rsp: got v=%b op=%0d e=%b d=%h want 1 0 1 0",
                     h_rsp[1].d_valid, h_rsp[1].d_opcode, h_rsp[1].d_error, h_rsp[1].d_data); end
        step();
        $display("test_unmapped done");
    endtask

    task automatic test_outstanding();
        host_req(0, Get, 32'h0001_0000, 8'h30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (h_rsp[0].a_ready !== (i < 4)) begin miscompares++;
                $display("FAIL lim_req%0d: got %b want %b", i, h_rsp[0].a_ready, (i < 4)); end
            step();
        end
        host_req(1, Get, 32'h0001_0000, 8'h31);
        @(negedge clk);
        vectors++; if (h_rsp[1].a_ready !== 1'b0 || d_req[1].a_valid !== 1'b0) begin miscompares++;
            $display("FAIL lim_fifo_full: got r=%b dv=%b want 0 0", h_rsp[1].a_ready, d_req[1].a_valid); end
        step();
        h_req[0].a_valid = 1'b0;
        h_req[1].a_valid = 1'b0;
        dev_resp(1, 1'b1, 8'h30, 32'h0000_1111);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL lim_rsp: got v0=%b v1=%b want 1 0", h_rsp[0].d_valid, h_rsp[1].d_valid); end
        step();
        step();
        dev_resp(1, 1'b0, 8'h00, 32'h0);
        host_req(0, Get, 32'h0003_0000, 8'h32);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (h_rsp[0].a_ready !== 1'b0 || d_req[3].a_valid !== 1'b0) begin miscompares++;
                $display("FAIL sw_stall%0d: got r=%b dv=%b want 0 0", i, h_rsp[0].a_ready, d_req[3].a_valid); end
            step();
            if (i == 0) dev_resp(1, 1'b1, 8'h30, 32'h0000_2222);
        end
        dev_resp(1, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1 || d_req[3].a_valid !== 1'b1) begin miscompares++;
            $display("FAIL sw_go: got r=%b dv=%b want 1 1", h_rsp[0].a_ready, d_req[3].a_valid); end
        step();
        h_req[0].a_valid = 1'b0;
        $display("test_outstanding done");
    endtask

    task automatic test_simultaneous();
        host_req(0, Get, 32'h0003_0004, 8'h40);
        dev_resp(3, 1'b1, 8'h32, 32'h0000_3333);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1 || h_rsp[0].d_valid !== 1'b1) begin miscompares++;
            $display("FAIL sim_both: got r=%b v=%b want 1 1", h_rsp[0].a_ready, h_rsp[0].d_valid); end
        step();
        dev_resp(3, 1'b0, 8'h00, 32'h0);
        host_req(0, Get, 32'h0000_0008, 8'h41);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b0) begin miscompares++;
            $display("FAIL sim_cnt_one: got %b want 0", h_rsp[0].a_ready); end
        step();
        dev_resp(3, 1'b1, 8'h40, 32'h0000_4444);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b0 || h_rsp[0].d_valid !== 1'b1) begin miscompares++;
            $display("FAIL sim_drain: got r=%b v=%b want 0 1", h_rsp[0].a_ready, h_rsp[0].d_valid); end
        step();
        dev_resp(3, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1) begin miscompares++;
            $display("FAIL sim_cnt_zero: got %b want 1", h_rsp[0].a_ready); end
        step();
        h_req[0].a_valid = 1'b0;
        dev_resp(0, 1'b1, 8'h41, 32'h0000_5555);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[0].d_data !== 32'h0000_5555) begin miscompares++;
            $display("FAIL sim_dev0_rsp: got v=%b d=%h want 1 00005555", h_rsp[0].d_valid, h_rsp[0].d_data); end
        step();
        dev_resp(0, 1'b0, 8'h00, 32'h0);
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        host_req(0, Get, 32'h0002_0000, 8'h50);
        repeat (3) step();
        h_req[0].a_valid = 1'b0;
        rst_ni = 1'b0;
        dev_resp(2, 1'b1, 8'h50, 32'h0000_6666);
        #1;
        vectors++; if (dev_valids() !== 4'b0000 || h_rsp[0].d_valid !== 1'b0 ||
                       h_rsp[1].d_valid !== 1'b0) begin miscompares++;
            $display("FAIL mrst_valids: got dv=%b v0=%b v1=%b want 0000 0 0",
                     dev_valids(), h_rsp[0].d_valid, h_rsp[1].d_valid); end
        vectors++; if (d_req[2].d_ready !== 1'b0) begin miscompares++;
            $display("FAIL mrst_dready: got %b want 0", d_req[2].d_ready); end
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b0 || d_req[2].d_ready !== 1'b0) begin miscompares++;
            $display("FAIL mrst_spurious: got v=%b rdy=%b want 0 0", h_rsp[0].d_valid, d_req[2].d_ready); end
        step();
        dev_resp(2, 1'b0, 8'h00, 32'h0);
        host_req(0, Get, 32'h0001_0008, 8'h51);
        @(negedge clk);
        vectors++; if (h_rsp[0].a_ready !== 1'b1 || d_req[1].a_valid !== 1'b1) begin miscompares++;
            $display("FAIL mrst_new_req: got r=%b dv=%b want 1 1", h_rsp[0].a_ready, d_req[1].a_valid); end
        step();
        h_req[0].a_valid = 1'b0;
        dev_resp(1, 1'b1, 8'h51, 32'hCAFE_F00D);
        @(negedge clk);
        vectors++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[0].d_data !== 32'hCAFE_F00D) begin miscompares++;
            $display("FAIL mrst_new_rsp: got v=%b d=%h want 1 cafef00d", h_rsp[0].d_valid, h_rsp[0].d_data); end
        step();
        dev_resp(1, 1'b0, 8'h00, 32'h0);
        $display("test_reset_mid done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_unmapped();
        test_outstanding();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
